// File: rtl/pe_col_drain_if.sv
// Output stream of the PE column drain: one signed word per handshake,
// tagged with its source PE and an end-of-snapshot marker.
interface pe_col_drain_if #(
  parameter int WORD_W = 24,
  parameter int IDX_W  = 3
);
  logic                     out_valid;
  logic                     out_ready;
  logic signed [WORD_W-1:0] out_data;
  logic [IDX_W-1:0]         out_pe_idx;
  logic                     out_last;

  // Drain side drives the word, sink side drives ready.
  modport master (
    output out_valid,
    output out_data,
    output out_pe_idx,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_pe_idx,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/pe_col_drain.sv
// Drain stage for a column of systolic PEs. A capture pulse snapshots all
// PE accumulator vectors plus the precision mode; the snapshot is then
// serialized as signed words, PE0 first, over a valid/ready stream.
//   mode 0 (8x8): two 24-bit sums per PE (bits [23:0], [47:24])
//   mode 1 (1x8): four 16-bit sums per PE, each sign-extended
// A capture landing on the final handshake reloads the snapshot with no
// bubble; any other capture during a drain is dropped and flagged.
// Optional build macro PE_DRAIN_RELU_EN clamps negative words to zero.
module pe_col_drain #(
  parameter int N_PE     = 8,
  parameter int PE_OUT_W = 64,
  parameter int WORD_W   = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mode,
  input  logic                     capture,
  input  logic [N_PE*PE_OUT_W-1:0] pe_out,
  output logic                     busy,
  output logic                     capture_drop,
  pe_col_drain_if.master           out_if
);

  localparam int IDX_W = (N_PE > 1) ? $clog2(N_PE) : 1;
  localparam logic [IDX_W-1:0] LAST_PE = IDX_W'(N_PE - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t state_q, state_nxt;

  // Unpack word j of one PE vector in the given precision mode.
  function automatic logic signed [WORD_W-1:0] unpack_word(
    input logic [PE_OUT_W-1:0] v,
    input logic                m,
    input logic [1:0]          j
  );
    logic [15:0]              h;
    logic signed [WORD_W-1:0] r;
    case (j)
      2'd0:    h = v[15:0];
      2'd1:    h = v[31:16];
      2'd2:    h = v[47:32];
      default: h = v[63:48];
    endcase
    if (m) r = {{(WORD_W-16){h[15]}}, h};
    else   r = j[0] ? v[2*WORD_W-1:WORD_W] : v[WORD_W-1:0];
    return r;
  endfunction

  // Optional rectification applied after sign extension.
  function automatic logic signed [WORD_W-1:0] relu_clamp(
    input logic signed [WORD_W-1:0] w
  );
`ifdef PE_DRAIN_RELU_EN
    return w[WORD_W-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  // snapshot stage
  logic [N_PE*PE_OUT_W-1:0] snap_p0;
  logic                     mode_p0;

  // output stage: current word indices and registered stream outputs
  logic [IDX_W-1:0]         pe_p1, pe_nxt;
  logic [1:0]               word_p1, word_nxt;
  logic signed [WORD_W-1:0] data_p1;
  logic                     last_p1, vld_p1, busy_p1, drop_p1;

  logic                     hs, final_hs, load;
  logic [1:0]               last_word_idx, src_last_idx;
  logic [N_PE*PE_OUT_W-1:0] src_vec;
  logic                     src_mode;
  logic [PE_OUT_W-1:0]      sel_vec;
  logic signed [WORD_W-1:0] word_sel;
  logic                     last_nxt;
  logic                     vld_nxt, drop_nxt, upd;

  // Handshake decode against the held snapshot.
  always_comb begin
    hs            = vld_p1 & out_if.out_ready;
    last_word_idx = mode_p0 ? 2'd3 : 2'd1;
    final_hs      = hs && (pe_p1 == LAST_PE) && (word_p1 == last_word_idx);
    load          = capture && ((state_q == IDLE) || final_hs);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (capture) state_nxt = DRAIN;
      DRAIN:   if (final_hs && !capture) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: next valid, drop flag and output-register update enable.
  always_comb begin
    vld_nxt  = (state_nxt == DRAIN);
    drop_nxt = (state_q == DRAIN) && capture && !final_hs;
    upd      = load || (hs && !final_hs);
  end

  // Word index advance: word wraps per mode, then steps to the next PE.
  always_comb begin
    pe_nxt   = pe_p1;
    word_nxt = word_p1;
    if (load || final_hs) begin
      pe_nxt   = '0;
      word_nxt = '0;
    end else if (hs) begin
      if (word_p1 == last_word_idx) begin
        word_nxt = '0;
        pe_nxt   = pe_p1 + 1'b1;
      end else begin
        word_nxt = word_p1 + 2'd1;
      end
    end
  end

  // Next word select; a loading capture reads pe_out directly so PE0
  // word0 is on the stream the cycle after capture.
  always_comb begin
    src_vec  = load ? pe_out : snap_p0;
    src_mode = load ? mode : mode_p0;
    sel_vec  = src_vec[PE_OUT_W-1:0];
    for (int k = 0; k < N_PE; k++) begin
      if (pe_nxt == IDX_W'(k)) sel_vec = src_vec[k*PE_OUT_W +: PE_OUT_W];
    end
    word_sel     = relu_clamp(unpack_word(sel_vec, src_mode, word_nxt));
    src_last_idx = src_mode ? 2'd3 : 2'd1;
    last_nxt     = (pe_nxt == LAST_PE) && (word_nxt == src_last_idx);
  end

  // Snapshot capture; later pe_out/mode changes do not touch the drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_p0 <= '0;
      mode_p0 <= 1'b0;
    end else if (load) begin
      snap_p0 <= pe_out;
      mode_p0 <= mode;
    end
  end

  // Registered stream outputs; word fields hold while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      busy_p1 <= 1'b0;
      drop_p1 <= 1'b0;
      pe_p1   <= '0;
      word_p1 <= '0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= vld_nxt;
      busy_p1 <= vld_nxt;
      drop_p1 <= drop_nxt;
      pe_p1   <= pe_nxt;
      word_p1 <= word_nxt;
      if (upd) begin
        data_p1 <= word_sel;
        last_p1 <= last_nxt;
      end else if (final_hs) begin
        last_p1 <= 1'b0;
      end
    end
  end

  assign out_if.out_valid  = vld_p1;
  assign out_if.out_data   = data_p1;
  assign out_if.out_pe_idx = pe_p1;
  assign out_if.out_last   = last_p1;
  assign busy              = busy_p1;
  assign capture_drop      = drop_p1;

endmodule

// File: tb/tb_pe_col_drain.sv
// Directed bench for pe_col_drain with N_PE=8: basic drains in both modes,
// backpressure, dropped capture, back-to-back reload and mid-drain reset.
module tb_pe_col_drain;

  logic         clk = 1'b0;
  logic         reset;
  logic         mode;
  logic         capture;
  logic [511:0] pe_out;
  logic         busy;
  logic         capture_drop;

  int vec_cnt = 0;
  int err_cnt = 0;

  pe_col_drain_if #(.WORD_W(24), .IDX_W(3)) bus ();

  pe_col_drain #(.N_PE(8), .PE_OUT_W(64), .WORD_W(24)) dut (
    .clk          (clk),
    .reset        (reset),
    .mode         (mode),
    .capture      (capture),
    .pe_out       (pe_out),
    .busy         (busy),
    .capture_drop (capture_drop),
    .out_if       (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] vec_a();
    logic [511:0] v;
    for (int k = 0; k < 8; k++) v[k*64 +: 64] = {16'h0, 24'(k + 256), 24'(-k)};
    return v;
  endfunction

  function automatic logic [511:0] vec_b();
    logic [511:0] v;
    for (int k = 0; k < 8; k++)
      v[k*64 +: 64] = {16'(k*256 + 3), 16'(k*256 + 2), 16'(k*256 + 1), 16'(k*256)};
    v[63:0] = 64'h8000_7FFF_FFFF_0001;
    return v;
  endfunction

  function automatic logic [511:0] vec_c();
    logic [511:0] v;
    for (int k = 0; k < 8; k++)
      v[k*64 +: 64] = {16'hDEAD, 24'(k*3 + 7), 24'(32'h0080_0000 + k)};
    return v;
  endfunction

  function automatic logic [23:0] model_word(input logic [511:0] v, input logic m, input int w);
    int          wpp;
    int          k;
    int          j;
    logic [63:0] pv;
    logic [15:0] h;
    logic [23:0] r;
    wpp = m ? 4 : 2;
    k   = w / wpp;
    j   = w % wpp;
    pv  = v[k*64 +: 64];
    h   = pv[j*16 +: 16];
    r   = m ? {{8{h[15]}}, h} : pv[j*24 +: 24];
`ifdef PE_DRAIN_RELU_EN
    if (r[23]) r = 24'h0;
`endif
    return r;
  endfunction

  task automatic chk_word(input string tag, input logic [511:0] v, input logic m, input int w);
    int wpp;
    wpp = m ? 4 : 2;
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_busy"},  64'(busy), 64'd1);
    chk({tag, "_data"},  64'($unsigned(bus.out_data)), 64'(model_word(v, m, w)));
    chk({tag, "_pe"},    64'(bus.out_pe_idx), 64'(w / wpp));
    chk({tag, "_last"},  64'(bus.out_last), 64'(w == 8*wpp - 1));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_idle_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_idle_busy"},  64'(busy), 64'd0);
  endtask

  task automatic start(input logic [511:0] v, input logic m);
    pe_out  = v;
    mode    = m;
    capture = 1'b1;
    tick();
    capture = 1'b0;
  endtask

  logic [511:0] va, vb, vc;
  logic [23:0]  hand_a [4];
  logic [23:0]  hand_b [4];
  int           idx;
  int           cyc;
  logic         rdy;

  initial begin
    va = vec_a();
    vb = vec_b();
    vc = vec_c();
`ifdef PE_DRAIN_RELU_EN
    hand_a = '{24'h000000, 24'h000100, 24'h000000, 24'h000101};
    hand_b = '{24'h000001, 24'h000000, 24'h007FFF, 24'h000000};
`else
    hand_a = '{24'h000000, 24'h000100, 24'hFFFFFF, 24'h000101};
    hand_b = '{24'h000001, 24'hFFFFFF, 24'h007FFF, 24'hFF8000};
`endif

    reset = 1'b1;
    mode = 1'b0;
    capture = 1'b0;
    pe_out = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_data",  64'($unsigned(bus.out_data)), 64'd0);
    chk("rst_pe",    64'(bus.out_pe_idx), 64'd0);
    chk("rst_last",  64'(bus.out_last), 64'd0);
    chk("rst_drop",  64'(capture_drop), 64'd0);
    reset = 1'b0;
    tick();

    // mode 0 basic drain; inputs scrambled after capture
    bus.out_ready = 1'b1;
    start(va, 1'b0);
    pe_out = '1;
    mode = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i < 4) chk("t1_hand", 64'($unsigned(bus.out_data)), 64'(hand_a[i]));
      chk_word("t1", va, 1'b0, i);
      tick();
    end
    chk_idle("t1");

    // mode 1 drain with sign extension
    start(vb, 1'b1);
    mode = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i < 4) chk("t2_hand", 64'($unsigned(bus.out_data)), 64'(hand_b[i]));
      chk_word("t2", vb, 1'b1, i);
      tick();
    end
    chk_idle("t2");

    // backpressure, ready pattern 1,0,0,1
    start(va, 1'b0);
    idx = 0;
    cyc = 0;
    while (idx < 16 && cyc < 200) begin
      chk_word("t3", va, 1'b0, idx);
      rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
      bus.out_ready = rdy;
      tick();
      if (rdy) idx++;
      cyc++;
    end
    chk("t3_count", 64'(idx), 64'd16);
    bus.out_ready = 1'b1;
    chk_idle("t3");

    // capture during drain is dropped
    start(va, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk_word("t4", va, 1'b0, i);
      if (i == 6) chk("t4_drop_pulse", 64'(capture_drop), 64'd1);
      if (i == 7) chk("t4_drop_clear", 64'(capture_drop), 64'd0);
      if (i == 5) begin
        capture = 1'b1;
        pe_out = vc;
        mode = 1'b1;
      end
      tick();
      capture = 1'b0;
    end
    chk_idle("t4");

    // capture on final handshake reloads with no bubble
    start(va, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk_word("t5a", va, 1'b0, i);
      if (i == 15) begin
        pe_out = vc;
        mode = 1'b0;
        capture = 1'b1;
      end
      tick();
      capture = 1'b0;
    end
    pe_out = '0;
    for (int i = 0; i < 16; i++) begin
      chk_word("t5b", vc, 1'b0, i);
      tick();
    end
    chk_idle("t5");

    // reset mid-drain at word 7, then restart
    start(vb, 1'b1);
    for (int i = 0; i < 7; i++) begin
      chk_word("t6a", vb, 1'b1, i);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_busy",  64'(busy), 64'd0);
    chk("t6_data",  64'($unsigned(bus.out_data)), 64'd0);
    chk("t6_pe",    64'(bus.out_pe_idx), 64'd0);
    chk("t6_last",  64'(bus.out_last), 64'd0);
    start(va, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk_word("t6b", va, 1'b0, i);
      tick();
    end
    chk_idle("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
